// File: rtl/clk_mgr_cfg_master.sv
// Clock-manager configuration master.
// On a start request it latches the requested DIVCLK/MULT/CLKOUT0 settings,
// writes them plus a load command to the clock manager over AXI4-Lite, then
// polls the status register until the lock bit is set or the poll budget
// runs out. A single done_o pulse and a sticky err_o report the outcome.
//
// Handshake semantics: a transfer on any AXI channel completes on a rising
// clk_i edge where that channel's valid and ready are both 1. A valid, once
// raised, stays high with its address/data unchanged until that edge, and
// drops in the following cycle. Only one transaction is ever outstanding,
// and AR is never driven while AW or W is active.
module clk_mgr_cfg_master #(
  parameter int unsigned POLL_LIMIT  = 1023,
  parameter logic [10:0] PLL_BASE    = 11'h200,
  parameter logic [10:0] STATUS_ADDR = 11'h004
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cfg_req_i,
  input  logic [7:0]  cfg_divclk_i,
  input  logic [7:0]  cfg_mult_i,
  input  logic [7:0]  cfg_div0_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [1:0]  err_o,
  output logic [2:0]  dbg_state_o,
  output logic [10:0] m_axi_awaddr,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic [10:0] m_axi_araddr,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_REQ  = 3'd1,
    S_WR_RESP = 3'd2,
    S_RD_REQ  = 3'd3,
    S_RD_RESP = 3'd4,
    S_FINISH  = 3'd5
  } state_t;

  localparam logic [10:0] REG2_ADDR = PLL_BASE + 11'h008;
  localparam logic [10:0] LOAD_ADDR = PLL_BASE + 11'h05C;
  localparam logic [16:0] POLL_LIM  = 17'(POLL_LIMIT);

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_BUS     = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  state_t      state_q, state_d;
  logic [1:0]  idx_q;
  logic [15:0] poll_q;
  logic [1:0]  err_q;
  logic        aw_done_q, w_done_q;
  logic [7:0]  divclk_q, mult_q, div0_q;

  logic        aw_hs, w_hs, aw_ok, w_ok;
  logic        b_ok, r_ok, locked, poll_hit;
  logic [16:0] poll_next;

  assign aw_hs     = m_axi_awvalid && m_axi_awready;
  assign w_hs      = m_axi_wvalid && m_axi_wready;
  // AW and W complete independently; the write request is finished once
  // both have been accepted, whether in the same cycle or different ones.
  assign aw_ok     = aw_done_q || aw_hs;
  assign w_ok      = w_done_q || w_hs;
  assign b_ok      = (m_axi_bresp == 2'b00);
  assign r_ok      = (m_axi_rresp == 2'b00);
  // Only bit 0 of the status word carries meaning (PLL locked).
  assign locked    = |(m_axi_rdata & 32'h0000_0001);
  assign poll_next = {1'b0, poll_q} + 17'd1;
  assign poll_hit  = (poll_next >= POLL_LIM);

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic for the configure / poll sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (cfg_req_i) state_d = S_WR_REQ;
      S_WR_REQ:  if (aw_ok && w_ok) state_d = S_WR_RESP;
      S_WR_RESP: begin
        if (m_axi_bvalid) begin
          if (!b_ok)             state_d = S_FINISH;
          else if (idx_q == 2'd2) state_d = S_RD_REQ;
          else                   state_d = S_WR_REQ;
        end
      end
      S_RD_REQ:  if (m_axi_arready) state_d = S_RD_RESP;
      S_RD_RESP: begin
        if (m_axi_rvalid) begin
          if (!r_ok || locked || poll_hit) state_d = S_FINISH;
          else                             state_d = S_RD_REQ;
        end
      end
      S_FINISH:  state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Sequence bookkeeping: latched settings, write index, poll count, result.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q     <= 2'd0;
      poll_q    <= 16'd0;
      err_q     <= ERR_OK;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      divclk_q  <= 8'd0;
      mult_q    <= 8'd0;
      div0_q    <= 8'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cfg_req_i) begin
            divclk_q  <= cfg_divclk_i;
            mult_q    <= cfg_mult_i;
            div0_q    <= cfg_div0_i;
            err_q     <= ERR_OK;
            idx_q     <= 2'd0;
            poll_q    <= 16'd0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
          end
        end
        S_WR_REQ: begin
          if (aw_ok && w_ok) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
          end else begin
            if (aw_hs) aw_done_q <= 1'b1;
            if (w_hs)  w_done_q  <= 1'b1;
          end
        end
        S_WR_RESP: begin
          if (m_axi_bvalid) begin
            if (!b_ok)              err_q  <= ERR_BUS;
            else if (idx_q == 2'd2) poll_q <= 16'd0;
            else                    idx_q  <= idx_q + 2'd1;
          end
        end
        S_RD_RESP: begin
          if (m_axi_rvalid) begin
            if (!r_ok) begin
              err_q <= ERR_BUS;
            end else if (!locked) begin
              poll_q <= poll_next[15:0];
              if (poll_hit) err_q <= ERR_TIMEOUT;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // AXI and status outputs decoded from the current state and write index.
  always_comb begin
    busy_o        = 1'b0;
    done_o        = 1'b0;
    m_axi_awaddr  = 11'd0;
    m_axi_awvalid = 1'b0;
    m_axi_wdata   = 32'd0;
    m_axi_wstrb   = 4'h0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_araddr  = 11'd0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    case (state_q)
      S_WR_REQ: begin
        busy_o        = 1'b1;
        m_axi_awvalid = !aw_done_q;
        m_axi_wvalid  = !w_done_q;
        m_axi_wstrb   = 4'hF;
        case (idx_q)
          2'd0: begin
            m_axi_awaddr = PLL_BASE;
            m_axi_wdata  = {16'h0000, mult_q, divclk_q};
          end
          2'd1: begin
            m_axi_awaddr = REG2_ADDR;
            m_axi_wdata  = {24'h000000, div0_q};
          end
          2'd2: begin
            m_axi_awaddr = LOAD_ADDR;
            m_axi_wdata  = 32'h0000_0003;
          end
          default: ;
        endcase
      end
      S_WR_RESP: begin
        busy_o       = 1'b1;
        m_axi_bready = 1'b1;
      end
      S_RD_REQ: begin
        busy_o        = 1'b1;
        m_axi_arvalid = 1'b1;
        m_axi_araddr  = STATUS_ADDR;
      end
      S_RD_RESP: begin
        busy_o       = 1'b1;
        m_axi_rready = 1'b1;
      end
      S_FINISH: done_o = 1'b1;
      default: ;
    endcase
  end

  assign err_o       = err_q;
  assign dbg_state_o = state_q;

endmodule
